hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter MUL_LAT, default 4, meaning multiply latency in cycles (range 2..255).
REQ-003 SHALL have parameter DIV_LAT, default 32, meaning divide latency in cycles (range 2..255).
REQ-004 SHALL have parameter CNT_W, default 32, meaning stall-counter width.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 RsD, RtD, RsE, RtE  in  REG_AW  source registers in Decode and Execute.
REQ-009 WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination register per stage.
REQ-010 RegWriteE, RegWriteM, RegWriteW  in  1  destination-write valid per stage.
REQ-011 MemtoRegE, MemtoRegM  in  1  load in E or M.
REQ-012 BranchD, JumpRegD  in  1  branch or register-jump resolving in Decode.
REQ-013 MdStartE  in  1  multiply/divide issued in E this cycle.
REQ-014 MdDivE  in  1  qualifies MdStartE: 1 = divide, 0 = multiply.
REQ-015 MdUseD  in  1  Decode instruction reads HI/LO or is a multiply/divide.
REQ-016 ForwardAE, ForwardBE  out  2  E operand select: 10 = M, 01 = W, 00 = register file.
REQ-017 ForwardAD, ForwardBD  out  1  Decode compare operand comes from M.
REQ-018 StallF, StallD, FlushE  out  1  pipeline control.
REQ-019 MdBusy  out  1  multiply/divide unit occupied.
REQ-020 StallCnt  out  CNT_W  count of stalled cycles.

Function
REQ-021 ForwardAE SHALL be 10 when RsE!=0, RsE==WriteRegM and RegWriteM; else 01 when RsE!=0, RsE==WriteRegW and RegWriteW; else 00. M SHALL take priority over W.
REQ-022 ForwardBE SHALL follow REQ-021 using RtE.
REQ-023 ForwardAD SHALL equal RsD!=0 & RsD==WriteRegM & RegWriteM. ForwardBD SHALL be the same using RtD.
REQ-024 lwstall SHALL equal MemtoRegE & RtE!=0 & (RsD==RtE | RtD==RtE).
REQ-025 brstall SHALL be asserted when (BranchD|JumpRegD) and either condition holds: RegWriteE & WriteRegE!=0 & WriteRegE in {RsD,RtD}; or MemtoRegM & WriteRegM!=0 & WriteRegM in {RsD,RtD}.
REQ-026 mdstall SHALL equal MdUseD & (MdBusy | MdStartE).
REQ-027 StallF, StallD and FlushE SHALL each equal lwstall | brstall | mdstall.
REQ-028 All forward and stall outputs SHALL be combinational, with zero latency.
REQ-029 Busy counter mdcnt, 8 bits: on MdStartE, mdcnt SHALL load DIV_LAT-1 when MdDivE=1, else MUL_LAT-1. Otherwise it SHALL decrement while nonzero.
REQ-030 MdStartE SHALL take priority over decrement in the same cycle (restart).
REQ-031 MdBusy SHALL equal mdcnt!=0. It SHALL fall exactly LAT cycles after the MdStartE cycle.
REQ-032 A Decode instruction with MdUseD SHALL proceed in the cycle MdBusy first reads 0, provided MdStartE=0 in that cycle.
REQ-033 StallCnt SHALL increment by 1 in each cycle StallD=1.
REQ-034 StallCnt SHALL saturate at all-ones (no wrap).

Reset
REQ-035 While reset_n=0 at a clk edge, mdcnt and StallCnt SHALL become 0.
REQ-036 After reset, MdBusy=0 and StallCnt=0; combinational outputs SHALL depend only on their inputs.
REQ-037 Reset asserted mid-operation SHALL abort any multiply/divide countdown immediately, with no residual stall.
REQ-038 Reset SHALL take priority over MdStartE.

Structure
REQ-039 A shared package SHALL hold the forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the default latency constants.
REQ-040 The busy countdown and saturating counter SHALL be implemented in one sub-module, md_busy_ctr.
REQ-041 The forwarding and stall logic SHALL remain in hazard_ctrl.

Verification
REQ-042 Forward priority: RsE=RtE=3, WriteRegM=WriteRegW=3, RegWriteM=RegWriteW=1 -> ForwardAE=ForwardBE=10. Then drop RegWriteM -> both 01. Then set RsE=0 -> ForwardAE=00.
REQ-043 Load-use: MemtoRegE=1, RtE=7, RsD=7 -> Stall/Flush=1 for one cycle. Repeat with RtE=0 -> no stall.
REQ-044 Branch: BranchD=1, RsD=4, RegWriteE=1, WriteRegE=4 -> stall. Next cycle (value now in M, non-load) -> no stall and ForwardAD=1.
REQ-045 Divide: MdStartE=1, MdDivE=1, MdUseD=1 held -> stall for exactly 32 cycles. MdBusy falls at cycle 32 and the stall releases that cycle.
REQ-046 Restart and reset: a multiply is started, then a divide in the following cycle -> MdBusy lasts 32 cycles from the second start. reset_n=0 mid-count -> MdBusy=0 and StallCnt=0 at the next edge.
REQ-047 Saturation: with CNT_W=4, hold a stall for 20 cycles -> StallCnt stays at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and default latencies for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned DEF_REG_AW  = 5;
  localparam int unsigned DEF_MUL_LAT = 4;
  localparam int unsigned DEF_DIV_LAT = 32;
  localparam int unsigned DEF_CNT_W   = 32;

  // Memory stage wins over writeback because it holds the younger result.
  function automatic fwd_sel_e fwd_sel(input logic hit_mem, input logic hit_wb);
    if (hit_mem)     return FWD_MEM;
    else if (hit_wb) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide occupancy countdown and saturating stall-cycle counter.
module md_busy_ctr
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             md_start,
  input  logic             md_div,
  input  logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

  logic [7:0] mdcnt;

  // Loading LAT-1 makes busy drop exactly LAT cycles after the start cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mdcnt <= '0;
    end else if (md_start) begin
      mdcnt <= md_div ? DIV_LOAD : MUL_LOAD;
    end else if (mdcnt != '0) begin
      mdcnt <= mdcnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign md_busy = (mdcnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, stall/flush generation.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              JumpRegD,
  input  logic              MdStartE,
  input  logic              MdDivE,
  input  logic              MdUseD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCnt
);

  logic lwstall, brstall, mdstall, stall;
  logic br_hit_e, br_hit_m;

  assign ForwardAE = fwd_sel((RsE != '0) && RegWriteM && (RsE == WriteRegM),
                             (RsE != '0) && RegWriteW && (RsE == WriteRegW));
  assign ForwardBE = fwd_sel((RtE != '0) && RegWriteM && (RtE == WriteRegM),
                             (RtE != '0) && RegWriteW && (RtE == WriteRegW));

  assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

  assign lwstall = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));

  // Decode-stage compares cannot take an E result or an in-flight load from M.
  assign br_hit_e = RegWriteE && (WriteRegE != '0) &&
                    ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign br_hit_m = MemtoRegM && (WriteRegM != '0) &&
                    ((WriteRegM == RsD) || (WriteRegM == RtD));
  assign brstall  = (BranchD || JumpRegD) && (br_hit_e || br_hit_m);

  assign mdstall = MdUseD && (MdBusy || MdStartE);

  assign stall  = lwstall || brstall || mdstall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  md_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_busy_ctr (
    .clk       (clk),
    .reset_n   (reset_n),
    .md_start  (MdStartE),
    .md_div    (MdDivE),
    .stall     (stall),
    .md_busy   (MdBusy),
    .stall_cnt (StallCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int AW      = 5;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic          BranchD, JumpRegD, MdStartE, MdDivE, MdUseD;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy;
  logic [31:0] StallCnt;

  logic [1:0]  s_ForwardAE, s_ForwardBE;
  logic        s_ForwardAD, s_ForwardBD, s_StallF, s_StallD, s_FlushE, s_MdBusy;
  logic [3:0]  s_StallCnt;

  hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpRegD(JumpRegD),
    .MdStartE(MdStartE), .MdDivE(MdDivE), .MdUseD(MdUseD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpRegD(JumpRegD),
    .MdStartE(MdStartE), .MdDivE(MdDivE), .MdUseD(MdUseD),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
    .StallF(s_StallF), .StallD(s_StallD), .FlushE(s_FlushE),
    .MdBusy(s_MdBusy), .StallCnt(s_StallCnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: cycle index, cycle at which the MD unit frees up, true stall total.
  int          cyc = 0;
  int          busy_until = 0;
  longint      scnt = 0;
  logic        last_stall, last_busy;

  function automatic logic [1:0] ref_fwd_e(input logic [AW-1:0] r);
    if (r != 0 && RegWriteM && r == WriteRegM) return 2'b10;
    if (r != 0 && RegWriteW && r == WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_fwd_d(input logic [AW-1:0] r);
    return (r != 0) && RegWriteM && (r == WriteRegM);
  endfunction

  function automatic logic ref_stall();
    logic lw, br, md;
    lw = MemtoRegE && RtE != 0 && (RsD == RtE || RtD == RtE);
    br = (BranchD || JumpRegD) &&
         ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
          (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
    md = MdUseD && ((cyc < busy_until) || MdStartE);
    return lw || br || md;
  endfunction

  task automatic idle();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, JumpRegD, MdStartE, MdDivE, MdUseD} = '0;
  endtask

  // Compare everything mid-cycle, then advance the model across the clock edge.
  task automatic cycle();
    logic st;
    logic busy;
    @(negedge clk);
    st   = ref_stall();
    busy = (cyc < busy_until);
    check("fwd_ae", ForwardAE, ref_fwd_e(RsE));
    check("fwd_be", ForwardBE, ref_fwd_e(RtE));
    check("fwd_ad", ForwardAD, ref_fwd_d(RsD));
    check("fwd_bd", ForwardBD, ref_fwd_d(RtD));
    check("stall_f", StallF, st);
    check("stall_d", StallD, st);
    check("flush_e", FlushE, st);
    check("md_busy", MdBusy, busy);
    check("md_busy_sat", s_MdBusy, busy);
    check("stall_cnt", StallCnt, (scnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : scnt);
    check("stall_cnt_sat", s_StallCnt, (scnt > 15) ? 15 : scnt);
    last_stall = StallD;
    last_busy  = MdBusy;
    @(posedge clk);
    if (!reset_n) begin
      busy_until = 0;
      scnt       = 0;
    end else begin
      if (MdStartE) busy_until = cyc + (MdDivE ? DIV_LAT : MUL_LAT);
      if (st) scnt++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int n;
    idle();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_busy", MdBusy, 1'b0);
    check("rst_cnt", StallCnt, 32'd0);
    cycle();

    // Forwarding priority
    RsE = 3; RtE = 3; WriteRegM = 3; WriteRegW = 3; RegWriteM = 1; RegWriteW = 1;
    #1;
    check("fwd_pri_a_mem", ForwardAE, 2'b10);
    check("fwd_pri_b_mem", ForwardBE, 2'b10);
    cycle();
    RegWriteM = 0;
    #1;
    check("fwd_pri_a_wb", ForwardAE, 2'b01);
    check("fwd_pri_b_wb", ForwardBE, 2'b01);
    cycle();
    RsE = 0;
    #1;
    check("fwd_r0", ForwardAE, 2'b00);
    cycle();

    // Load-use
    idle(); MemtoRegE = 1; RtE = 7; RsD = 7;
    #1;
    check("lw_stall", StallD, 1'b1);
    cycle();
    RtE = 0; RsD = 0;
    #1;
    check("lw_r0", StallD, 1'b0);
    cycle();

    // Branch on an E result, then the same value from M
    idle(); BranchD = 1; RsD = 4; RegWriteE = 1; WriteRegE = 4;
    #1;
    check("br_stall", StallD, 1'b1);
    cycle();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 4;
    #1;
    check("br_go", StallD, 1'b0);
    check("br_fwd_ad", ForwardAD, 1'b1);
    cycle();

    // Divide with a dependent Decode instruction held
    idle(); MdStartE = 1; MdDivE = 1; MdUseD = 1;
    cycle();
    n = last_stall ? 1 : 0;
    MdStartE = 0; MdDivE = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (!last_stall) break;
      n++;
    end
    check("div_stall_len", n, 32);
    check("div_release_busy", last_busy, 1'b0);

    // Multiply then divide restart
    idle(); MdStartE = 1; MdDivE = 0;
    cycle();
    MdDivE = 1;
    cycle();
    MdStartE = 0; MdDivE = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (!last_busy) break;
      n++;
    end
    check("restart_busy_len", n, DIV_LAT - 1);

    // Reset mid-countdown
    MdStartE = 1; MdDivE = 1;
    cycle();
    MdStartE = 0; MdDivE = 0; MdUseD = 1;
    for (int k = 0; k < 5; k++) cycle();
    reset_n = 0;
    cycle();
    reset_n = 1;
    cycle();
    check("rst_mid_busy", last_busy, 1'b0);
    check("rst_mid_stall", last_stall, 1'b0);
    check("rst_mid_cnt", StallCnt, 32'd0);

    // Saturation of the narrow counter
    MdStartE = 1; MdUseD = 1;
    for (int k = 0; k < 20; k++) cycle();
    check("sat_cnt", s_StallCnt, 4'd15);
    check("wide_cnt", StallCnt, 32'd20);
    idle();
    cycle();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      RsD = AW'($urandom_range(0, 3)); RtD = AW'($urandom_range(0, 3));
      RsE = AW'($urandom_range(0, 3)); RtE = AW'($urandom_range(0, 3));
      WriteRegE = AW'($urandom_range(0, 3));
      WriteRegM = AW'($urandom_range(0, 3));
      WriteRegW = AW'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom); MemtoRegM = 1'($urandom);
      BranchD   = ($urandom_range(0, 3) == 0);
      JumpRegD  = ($urandom_range(0, 5) == 0);
      MdStartE  = ($urandom_range(0, 9) == 0);
      MdDivE    = 1'($urandom);
      MdUseD    = 1'($urandom);
      reset_n   = ($urandom_range(0, 59) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
